sample_queue: RTL

Stereo circular sample queue between the CODEC interface and the equalizer FIR engine. Stores each new left/right sample pair in a 1024-deep circular buffer. Once 1021 samples have been buffered, each new sample triggers a read burst that streams the 1021 most recent samples, oldest first, to the FIR band filters. The FIR engine asserts amplifier-on only after this queue reports `filled`.

---
 rtl/eq_pkg.sv | 10 +
 rtl/sample_queue_if.sv | 21 ++
 rtl/dp_ram.sv | 27 ++
 rtl/sample_queue.sv | 94 +++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared equalizer types and default sizes for the stereo sample queue.
package eq_pkg;
  localparam int SMPL_W   = 16;
  localparam int Q_DEPTH  = 1024;
  localparam int Q_RD_LEN = 1021;

  typedef logic signed [SMPL_W-1:0] smpl_t;

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} q_state_t;
endpackage

// File: rtl/sample_queue_if.sv
// CODEC-side write strobe/samples and FIR-side burst outputs of the sample queue.
interface sample_queue_if #(parameter int SMPL_W = eq_pkg::SMPL_W);
  logic                     wrt_smpl;
  logic signed [SMPL_W-1:0] lft_smpl;
  logic signed [SMPL_W-1:0] rht_smpl;
  logic signed [SMPL_W-1:0] lft_out;
  logic signed [SMPL_W-1:0] rht_out;
  logic                     sequencing;
  logic                     filled;
  logic                     overrun;

  modport master (
    output wrt_smpl, lft_smpl, rht_smpl,
    input  lft_out, rht_out, sequencing, filled, overrun
  );

  modport slave (
    input  wrt_smpl, lft_smpl, rht_smpl,
    output lft_out, rht_out, sequencing, filled, overrun
  );
endinterface

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port that holds when idle.
module dp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sample_queue.sv
// Stereo circular sample queue: buffers CODEC pairs and streams the RD_LEN most
// recent pairs, oldest first, to the FIR engine after every new sample.
module sample_queue #(
  parameter int SMPL_W = eq_pkg::SMPL_W,
  parameter int DEPTH  = eq_pkg::Q_DEPTH,
  parameter int RD_LEN = eq_pkg::Q_RD_LEN
) (
  input  logic           clk,
  input  logic           rst,
  sample_queue_if.slave  q
);
  import eq_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RD_LEN + 1);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(RD_LEN);
  localparam logic [CNT_W-1:0] FILL_PRE = CNT_W'(RD_LEN - 1);
  localparam logic [PTR_W-1:0] LAST_RD  = PTR_W'(RD_LEN - 1);

  q_state_t            state;
  logic [PTR_W-1:0]    new_ptr, old_ptr, rd_ptr, rd_cnt;
  logic [CNT_W-1:0]    fill_cnt;
  logic                filled_r, overrun_r, seq_r;
  logic [2*SMPL_W-1:0] rdata;
  logic                rd_issue;

  assign rd_issue = (state == READ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      new_ptr   <= '0;
      old_ptr   <= '0;
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      fill_cnt  <= '0;
      filled_r  <= 1'b0;
      overrun_r <= 1'b0;
      seq_r     <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      // Data for a read issued this cycle appears next cycle.
      seq_r     <= rd_issue;

      if (q.wrt_smpl) begin
        new_ptr <= new_ptr + 1'b1;
        if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (q.wrt_smpl && (filled_r || fill_cnt == FILL_PRE)) begin
            state    <= READ;
            rd_cnt   <= '0;
            filled_r <= 1'b1;
            // Once full, each burst slides the window one sample forward;
            // the very first burst starts at address 0.
            if (filled_r) begin
              rd_ptr  <= old_ptr + 1'b1;
              old_ptr <= old_ptr + 1'b1;
            end else begin
              rd_ptr  <= old_ptr;
            end
          end
        end
        READ: begin
          rd_ptr <= rd_ptr + 1'b1;
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_cnt == LAST_RD) state <= IDLE;
          // Sample is stored but its burst is dropped.
          if (q.wrt_smpl) overrun_r <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dp_ram #(.WIDTH(2*SMPL_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (q.wrt_smpl),
    .waddr (new_ptr),
    .wdata ({q.lft_smpl, q.rht_smpl}),
    .re    (rd_issue),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign q.lft_out    = rdata[2*SMPL_W-1:SMPL_W];
  assign q.rht_out    = rdata[SMPL_W-1:0];
  assign q.sequencing = seq_r;
  assign q.filled     = filled_r;
  assign q.overrun    = overrun_r;
endmodule
